// File: rtl/id_operand_unit_pkg.sv
// id_operand_unit_pkg: shared register and bypass-stage definitions for the decode operand path
package id_operand_unit_pkg;
  localparam int REG_ZERO = 0;
  localparam int BYP_EXE = 0;
  localparam int BYP_MEM = 1;
  localparam int BYP_MEM2 = 2;
  localparam int BYP_WB = 3;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  typedef struct packed {
    logic wr;
    logic rdy;
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_DATA_W-1:0] data;
  } byp_stage_t;
endpackage

// File: rtl/id_operand_unit_if.sv
// id_operand_unit_if: decode-stage operand bus between pipeline control and the operand unit
interface id_operand_unit_if #(
  parameter int NUM_RD = 2,
  parameter int NUM_BYP = 4,
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 32
);
  logic                      id_valid;
  logic [NUM_RD*ADDR_W-1:0]  id_src;
  logic [NUM_RD-1:0]         id_src_used;
  logic [ADDR_W-1:0]         id_dst;
  logic                      id_wr;
  logic                      id_long;
  logic                      ex_ready;
  logic                      flush;
  logic [NUM_BYP-1:0]        byp_wr;
  logic [NUM_BYP*ADDR_W-1:0] byp_dst;
  logic [NUM_BYP-1:0]        byp_rdy;
  logic [NUM_BYP*DATA_W-1:0] byp_data;
  logic                      wb_wr;
  logic [ADDR_W-1:0]         wb_dst;
  logic [DATA_W-1:0]         wb_data;
  logic                      ll_done;
  logic [ADDR_W-1:0]         ll_dst;
  logic [NUM_RD*DATA_W-1:0]  id_opnd;
  logic                      id_stall;
  logic                      id_fire;
  logic [REG_CNT-1:0]        sb_busy;
  logic [CNT_W-1:0]          stall_cnt;
  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_wr, id_long, ex_ready, flush,
           byp_wr, byp_dst, byp_rdy, byp_data, wb_wr, wb_dst, wb_data, ll_done, ll_dst,
    input  id_opnd, id_stall, id_fire, sb_busy, stall_cnt
  );
  modport slave (
    input  id_valid, id_src, id_src_used, id_dst, id_wr, id_long, ex_ready, flush,
           byp_wr, byp_dst, byp_rdy, byp_data, wb_wr, wb_dst, wb_data, ll_done, ll_dst,
    output id_opnd, id_stall, id_fire, sb_busy, stall_cnt
  );
endinterface

// File: rtl/id_operand_unit_rf_multiread.sv
// rf_multiread: multi-port register file, register 0 hardwired to zero, write-through on read
module rf_multiread
  import id_operand_unit_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [REG_CNT];
  logic [ADDR_W-1:0] a;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int r = 0; r < REG_CNT; r++) mem[r] <= '0;
    else if (wr && int'(wa) != REG_ZERO) mem[wa] <= wd;
  end
  always_comb begin
    rd = '0;
    a = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = ra[p*ADDR_W +: ADDR_W];
      rd[p*DATA_W +: DATA_W] = int'(a) == REG_ZERO ? '0 : (wr && a == wa) ? wd : mem[a];
    end
  end
endmodule

// File: rtl/id_operand_unit.sv
// id_operand_unit: decode operand forwarding, hazard stall/fire and long-latency scoreboard
module id_operand_unit
  import id_operand_unit_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int NUM_BYP = 4,
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  id_operand_unit_if.slave bus
);
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD*DATA_W-1:0] opnd;
  logic [REG_CNT-1:0]       sb, sb_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [ADDR_W-1:0]        s;
  logic [DATA_W-1:0]        d;
  logic                     hit, rdy, hz, stall, fire, set;
  rf_multiread #(.NUM_RD(NUM_RD), .DATA_W(DATA_W), .REG_CNT(REG_CNT), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk), .rst(rst), .wr(bus.wb_wr), .wa(bus.wb_dst), .wd(bus.wb_data),
    .ra(bus.id_src), .rd(rd)
  );
  // Scan oldest to youngest so the youngest matching stage overwrites the selection
  always_comb begin
    hz = 1'b0;
    opnd = '0;
    s = '0;
    d = '0;
    hit = 1'b0;
    rdy = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      s = bus.id_src[p*ADDR_W +: ADDR_W];
      d = rd[p*DATA_W +: DATA_W];
      hit = 1'b0;
      rdy = 1'b0;
      for (int i = NUM_BYP-1; i >= BYP_EXE; i--) begin
        if (bus.byp_wr[i] && bus.byp_dst[i*ADDR_W +: ADDR_W] == s && int'(s) != REG_ZERO) begin
          hit = 1'b1;
          rdy = bus.byp_rdy[i];
          d = bus.byp_data[i*DATA_W +: DATA_W];
        end
      end
      opnd[p*DATA_W +: DATA_W] = d;
      hz = hz | (bus.id_src_used[p] & ((hit & ~rdy) | sb[s]));
    end
    hz = hz | (bus.id_wr & (int'(bus.id_dst) != REG_ZERO) & sb[bus.id_dst]);
  end
  assign stall = bus.id_valid & hz & ~bus.flush;
  assign fire = bus.id_valid & ~hz & bus.ex_ready & ~bus.flush;
  assign set = fire & bus.id_long & bus.id_wr & (int'(bus.id_dst) != REG_ZERO);
  // A same-register set wins over a completing clear
  always_comb begin
    sb_nxt = sb;
    if (bus.ll_done) sb_nxt[bus.ll_dst] = 1'b0;
    if (set) sb_nxt[bus.id_dst] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
      cnt <= '0;
    end else begin
      sb <= sb_nxt;
      cnt <= cnt + {{(CNT_W-1){1'b0}}, stall & ~&cnt};
    end
  end
  assign bus.id_opnd = opnd;
  assign bus.id_stall = stall;
  assign bus.id_fire = fire;
  assign bus.sb_busy = sb;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_id_operand_unit.sv
// tb_id_operand_unit: directed and randomized checks of the operand unit against a behavioural model
module tb_id_operand_unit;
  import id_operand_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  id_operand_unit_if bus();
  byp_stage_t byp [4];
  for (genvar g = 0; g < 4; g++) begin : g_byp
    assign bus.byp_wr[g] = byp[g].wr;
    assign bus.byp_rdy[g] = byp[g].rdy;
    assign bus.byp_dst[g*5 +: 5] = byp[g].dst;
    assign bus.byp_data[g*32 +: 32] = byp[g].data;
  end
  id_operand_unit dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] rf_m [32];
  logic [31:0] busy_m;
  logic [31:0] cnt_m;
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] m_opnd(int p);
    logic [4:0] a;
    a = bus.id_src[p*5 +: 5];
    if (a == 0) return 0;
    for (int i = 0; i < 4; i++) if (byp[i].wr && byp[i].dst == a) return byp[i].data;
    if (bus.wb_wr && bus.wb_dst == a) return bus.wb_data;
    return rf_m[a];
  endfunction

  function automatic bit m_hazard();
    bit h;
    logic [4:0] a;
    bit found;
    h = 0;
    for (int p = 0; p < 2; p++) begin
      a = bus.id_src[p*5 +: 5];
      found = 0;
      if (bus.id_src_used[p] && a != 0) begin
        if (busy_m[a]) h = 1;
        for (int i = 0; i < 4; i++)
          if (!found && byp[i].wr && byp[i].dst == a) begin
            found = 1;
            if (!byp[i].rdy) h = 1;
          end
      end
    end
    if (bus.id_wr && bus.id_dst != 0 && busy_m[bus.id_dst]) h = 1;
    return h;
  endfunction

  task automatic clear_in();
    bus.id_valid = 0; bus.id_src = '0; bus.id_src_used = '0; bus.id_dst = '0;
    bus.id_wr = 0; bus.id_long = 0; bus.ex_ready = 0; bus.flush = 0;
    bus.wb_wr = 0; bus.wb_dst = '0; bus.wb_data = '0; bus.ll_done = 0; bus.ll_dst = '0;
    for (int i = 0; i < 4; i++) byp[i] = '0;
  endtask

  task automatic tick();
    bit h, st, fi;
    h = m_hazard();
    st = bus.id_valid && h && !bus.flush;
    fi = bus.id_valid && !h && bus.ex_ready && !bus.flush;
    @(posedge clk);
    if (st && cnt_m != 32'hffff_ffff) cnt_m++;
    if (bus.wb_wr && bus.wb_dst != 0) rf_m[bus.wb_dst] = bus.wb_data;
    if (bus.ll_done) busy_m[bus.ll_dst] = 0;
    if (fi && bus.id_long && bus.id_wr && bus.id_dst != 0) busy_m[bus.id_dst] = 1;
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) rf_m[r] = 0;
    busy_m = 0;
    cnt_m = 0;
  endtask

  task automatic test_reset();
    model_reset();
    clear_in();
    bus.id_src = {5'd3, 5'd4};
    bus.id_src_used = 2'b11;
    #12;
    total++; if (bus.sb_busy !== 32'h0) begin bad++; $display("FAIL rst_busy got=%h exp=0", bus.sb_busy); end
    total++; if (bus.stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cnt); end
    total++; if (bus.id_opnd !== 64'h0) begin bad++; $display("FAIL rst_opnd got=%h exp=0", bus.id_opnd); end
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b00) begin bad++; $display("FAIL rst_sf got=%b exp=00", {bus.id_stall, bus.id_fire}); end
    @(posedge clk); #1;
    rst = 0;
    clear_in();
  endtask

  task automatic test_bypass_priority();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1;
    bus.id_src = {5'd0, 5'd5}; bus.id_src_used = 2'b01;
    byp[BYP_EXE] = '{wr: 1, rdy: 1, dst: 5, data: 32'h11};
    byp[BYP_MEM2] = '{wr: 1, rdy: 1, dst: 5, data: 32'h22};
    @(negedge clk);
    total++; if (bus.id_opnd[31:0] !== 32'h11) begin bad++; $display("FAIL bp_opnd got=%h exp=11", bus.id_opnd[31:0]); end
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b01) begin bad++; $display("FAIL bp_sf got=%b exp=01", {bus.id_stall, bus.id_fire}); end
    tick();
    clear_in();
  endtask

  task automatic test_load_use();
    logic [31:0] c0;
    clear_in();
    c0 = cnt_m;
    bus.id_valid = 1; bus.ex_ready = 1;
    bus.id_src = {5'd7, 5'd0}; bus.id_src_used = 2'b10;
    byp[BYP_EXE] = '{wr: 1, rdy: 0, dst: 7, data: 32'hdead};
    byp[BYP_MEM] = '{wr: 1, rdy: 1, dst: 7, data: 32'h33};
    @(negedge clk);
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b10) begin bad++; $display("FAIL lu_sf got=%b exp=10", {bus.id_stall, bus.id_fire}); end
    total++; if (bus.stall_cnt !== c0) begin bad++; $display("FAIL lu_cnt0 got=%0d exp=%0d", bus.stall_cnt, c0); end
    tick();
    total++; if (bus.stall_cnt !== c0 + 1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=%0d", bus.stall_cnt, c0 + 1); end
    tick();
    total++; if (bus.stall_cnt !== c0 + 2) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=%0d", bus.stall_cnt, c0 + 2); end
    byp[BYP_EXE] = '{wr: 1, rdy: 1, dst: 7, data: 32'h44};
    @(negedge clk);
    total++; if (bus.id_opnd[63:32] !== 32'h44) begin bad++; $display("FAIL lu_opnd got=%h exp=44", bus.id_opnd[63:32]); end
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b01) begin bad++; $display("FAIL lu_fire got=%b exp=01", {bus.id_stall, bus.id_fire}); end
    tick();
    total++; if (bus.stall_cnt !== c0 + 2) begin bad++; $display("FAIL lu_cnt3 got=%0d exp=%0d", bus.stall_cnt, c0 + 2); end
    clear_in();
  endtask

  task automatic test_long_latency();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_long = 1; bus.id_wr = 1; bus.id_dst = 9;
    @(negedge clk);
    total++; if (bus.id_fire !== 1'b1) begin bad++; $display("FAIL ll_fire0 got=%b exp=1", bus.id_fire); end
    tick();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_src = {5'd0, 5'd9}; bus.id_src_used = 2'b01;
    @(negedge clk);
    total++; if (bus.sb_busy[9] !== 1'b1) begin bad++; $display("FAIL ll_busy got=%b exp=1", bus.sb_busy[9]); end
    total++; if (bus.id_stall !== 1'b1) begin bad++; $display("FAIL ll_stall0 got=%b exp=1", bus.id_stall); end
    tick();
    tick();
    bus.ll_done = 1; bus.ll_dst = 9;
    @(negedge clk);
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b10) begin bad++; $display("FAIL ll_stall_done got=%b exp=10", {bus.id_stall, bus.id_fire}); end
    tick();
    bus.ll_done = 0;
    @(negedge clk);
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b01) begin bad++; $display("FAIL ll_release got=%b exp=01", {bus.id_stall, bus.id_fire}); end
    total++; if (bus.sb_busy[9] !== 1'b0) begin bad++; $display("FAIL ll_clear got=%b exp=0", bus.sb_busy[9]); end
    tick();
    clear_in();
  endtask

  task automatic test_collision();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_long = 1; bus.id_wr = 1; bus.id_dst = 3;
    bus.ll_done = 1; bus.ll_dst = 3;
    @(negedge clk);
    total++; if (bus.id_fire !== 1'b1) begin bad++; $display("FAIL col_fire got=%b exp=1", bus.id_fire); end
    tick();
    bus.ll_done = 0; bus.id_long = 0;
    @(negedge clk);
    total++; if (bus.sb_busy[3] !== 1'b1) begin bad++; $display("FAIL col_setwins got=%b exp=1", bus.sb_busy[3]); end
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b10) begin bad++; $display("FAIL col_waw got=%b exp=10", {bus.id_stall, bus.id_fire}); end
    tick();
    bus.id_long = 1; bus.ll_done = 1; bus.ll_dst = 3;
    @(negedge clk);
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b10) begin bad++; $display("FAIL col_waw_done got=%b exp=10", {bus.id_stall, bus.id_fire}); end
    tick();
    clear_in();
    @(negedge clk);
    total++; if (bus.sb_busy !== busy_m) begin bad++; $display("FAIL col_busy got=%h exp=%h", bus.sb_busy, busy_m); end
  endtask

  task automatic test_r0_unused();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_src = {5'd0, 5'd0}; bus.id_src_used = 2'b11;
    byp[BYP_EXE] = '{wr: 1, rdy: 0, dst: 0, data: 32'h55};
    bus.wb_wr = 1; bus.wb_dst = 0; bus.wb_data = 32'hffff;
    @(negedge clk);
    total++; if (bus.id_opnd !== 64'h0) begin bad++; $display("FAIL r0_opnd got=%h exp=0", bus.id_opnd); end
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b01) begin bad++; $display("FAIL r0_sf got=%b exp=01", {bus.id_stall, bus.id_fire}); end
    tick();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_src = {5'd6, 5'd0}; bus.id_src_used = 2'b01;
    byp[BYP_EXE] = '{wr: 1, rdy: 0, dst: 6, data: 32'h66};
    @(negedge clk);
    total++; if ({bus.id_stall, bus.id_fire} !== 2'b01) begin bad++; $display("FAIL unused_sf got=%b exp=01", {bus.id_stall, bus.id_fire}); end
    tick();
    clear_in();
  endtask

  task automatic test_random();
    bit h;
    for (int n = 0; n < 400; n++) begin
      bus.id_valid = ($urandom % 4) != 0;
      bus.id_src = {5'($urandom % 8), 5'($urandom % 8)};
      bus.id_src_used = 2'($urandom);
      bus.id_dst = 5'($urandom % 8);
      bus.id_wr = 1'($urandom);
      bus.id_long = ($urandom % 5) == 0;
      bus.ex_ready = ($urandom % 4) != 0;
      bus.flush = ($urandom % 10) == 0;
      for (int i = 0; i < 4; i++)
        byp[i] = '{wr: 1'($urandom), rdy: ($urandom % 4) != 0, dst: 5'($urandom % 8), data: $urandom};
      bus.wb_wr = 1'($urandom);
      bus.wb_dst = 5'($urandom % 8);
      bus.wb_data = $urandom;
      bus.ll_done = ($urandom % 3) == 0;
      bus.ll_dst = 5'($urandom % 8);
      @(negedge clk);
      h = m_hazard();
      for (int p = 0; p < 2; p++) begin
        total++; if (bus.id_opnd[p*32 +: 32] !== m_opnd(p)) begin bad++; $display("FAIL rnd_opnd%0d n=%0d got=%h exp=%h", p, n, bus.id_opnd[p*32 +: 32], m_opnd(p)); end
      end
      total++; if (bus.id_stall !== (bus.id_valid & h & ~bus.flush)) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.id_stall, bus.id_valid & h & ~bus.flush); end
      total++; if (bus.id_fire !== (bus.id_valid & ~h & bus.ex_ready & ~bus.flush)) begin bad++; $display("FAIL rnd_fire n=%0d got=%b exp=%b", n, bus.id_fire, bus.id_valid & ~h & bus.ex_ready & ~bus.flush); end
      total++; if (bus.sb_busy !== busy_m) begin bad++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, bus.sb_busy, busy_m); end
      total++; if (bus.stall_cnt !== cnt_m) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.stall_cnt, cnt_m); end
      tick();
    end
    clear_in();
  endtask

  task automatic test_async_reset();
    clear_in();
    bus.wb_wr = 1; bus.wb_dst = 12; bus.wb_data = 32'hdead_beef;
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_long = 1; bus.id_wr = 1; bus.id_dst = 13;
    tick();
    clear_in();
    bus.id_valid = 1; bus.ex_ready = 1; bus.id_src = {5'd12, 5'd13}; bus.id_src_used = 2'b01;
    @(negedge clk);
    total++; if (bus.id_stall !== 1'b1) begin bad++; $display("FAIL ar_pre_stall got=%b exp=1", bus.id_stall); end
    total++; if (bus.id_opnd[63:32] !== 32'hdead_beef) begin bad++; $display("FAIL ar_pre_rf got=%h exp=deadbeef", bus.id_opnd[63:32]); end
    tick();
    @(negedge clk); #2;
    rst = 1;
    bus.id_valid = 0;
    #1;
    model_reset();
    total++; if (bus.sb_busy !== 32'h0) begin bad++; $display("FAIL ar_busy got=%h exp=0", bus.sb_busy); end
    total++; if (bus.stall_cnt !== 32'h0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", bus.stall_cnt); end
    total++; if (bus.id_opnd !== 64'h0) begin bad++; $display("FAIL ar_rf got=%h exp=0", bus.id_opnd); end
    @(posedge clk); #1;
    rst = 0;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_bypass_priority();
    test_load_use();
    test_long_latency();
    test_collision();
    test_r0_unused();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
- Parametrised successor of the decode-stage operand path. Integrates a multi-read-port register file, a generic N-stage priority bypass network, and a long-latency scoreboard.
- Produces forwarded source operands, a hazard stall and an issue-fire handshake toward EXE.
- Sits between the IF/ID register and the ID/EXE register. Replaces fixed two-operand, fixed four-stage forwarding and load-stall logic.

Parameters:
- NUM_RD, 2, number of source-operand read ports
- NUM_BYP, 4, number of bypass stages; index 0 = youngest (EXE), NUM_BYP-1 = oldest
- DATA_W, 32, register data width
- REG_CNT, 32, architectural registers; register 0 hardwired to zero
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= REG_CNT
- CNT_W, 32, stall performance counter width

Ports:
- clk in 1 clock
- rst in 1 reset, asynchronous, active-high
- id_valid in 1 instruction present in ID
- id_src in NUM_RD*ADDR_W source register addresses
- id_src_used in NUM_RD per-port "operand actually read"
- id_dst in ADDR_W destination register
- id_wr in 1 instruction writes id_dst
- id_long in 1 instruction is long-latency (div/mul/mfc0-class)
- ex_ready in 1 EXE can accept
- flush in 1 ID flush
- byp_wr in NUM_BYP stage writes a register
- byp_dst in NUM_BYP*ADDR_W stage destination
- byp_rdy in NUM_BYP stage result valid (0 = load/unfinished)
- byp_data in NUM_BYP*DATA_W stage result
- wb_wr in 1 register-file write enable
- wb_dst in ADDR_W write address
- wb_data in DATA_W write data
- ll_done in 1 long-latency op completed
- ll_dst in ADDR_W completed op destination
- id_opnd out NUM_RD*DATA_W forwarded operands
- id_stall out 1 hazard stall request
- id_fire out 1 instruction issues this cycle
- sb_busy out REG_CNT scoreboard busy vector
- stall_cnt out CNT_W hazard-stall cycle count

Behaviour:
- Reset (async, rst=1): all RF entries 0, sb_busy=0, stall_cnt=0. id_stall=0 and id_fire=0 because id_valid is assumed low by the pipeline during reset.
- RF read: combinational. Register 0 always reads 0; writes to register 0 are ignored.
- RF write: on posedge clk when wb_wr=1 and wb_dst!=0.
- Same-cycle WB-to-read bypass is internal: a read with address == wb_dst while wb_wr=1 returns wb_data.
- Bypass match, port p, stage i: byp_wr[i] & byp_dst[i]==src[p] & src[p]!=0.
  - The lowest matching index (youngest) wins.
  - If that winning stage has byp_rdy=0, it is a data hazard on port p; older matches are never used.
  - No match: the RF/WB value is used.
- Scoreboard hazard on port p: id_src_used[p] & sb_busy[src[p]].
- WAW hazard: id_wr & id_dst!=0 & sb_busy[id_dst].
- hazard = OR over ports of (id_src_used[p] & (bypass hazard | scoreboard hazard)) | WAW hazard.
- id_stall = id_valid & hazard & ~flush.
- id_fire = id_valid & ~hazard & ex_ready & ~flush.
- Scoreboard update (posedge):
  - Set busy[id_dst] when id_fire & id_long & id_wr & id_dst!=0.
  - Clear busy[ll_dst] when ll_done.
  - If set and clear target the same register in the same cycle, set wins.
  - A clear is visible to hazard logic only from the next cycle; there is no same-cycle ll_done bypass.
- flush: suppresses fire and stall; scoreboard and RF unaffected. In-flight long ops still complete and clear.
- stall_cnt: +1 each cycle id_stall=1; saturates at all-ones.
- ex_ready=0 with no hazard: id_fire=0, id_stall=0 (backpressure is not counted).
- Operand latency: combinational from inputs to id_opnd; no internal pipeline register.

Decomposition:
- Shared package (cpu defines): REG_ZERO constant, bypass-stage index constants (BYP_EXE=0, BYP_MEM=1, BYP_MEM2=2, BYP_WB=3), and a packed struct for one bypass stage (wr, rdy, dst, data).
- Sub-module rf_multiread: REG_CNT x DATA_W storage with NUM_RD read ports, one write port and internal write-through. The bypass network, scoreboard and counter stay in the top.

Test Plan:
- Bypass priority: byp0 writes r5=0x11 rdy=1, byp2 writes r5=0x22, src0=r5 used -> id_opnd[0]=0x11, id_fire=1 with ex_ready=1.
- Load-use: byp0 r7 rdy=0, byp1 r7=0x33 rdy=1, src1=r7 used -> id_stall=1, id_fire=0, stall_cnt increments by 1 per cycle; byp0 rdy=1 data 0x44 -> operand 0x44, fire.
- Long-latency: fire id_long writing r9; next instruction reads r9 -> stall until ll_done r9 pulses, then stall the following cycle still high, clears the cycle after.
- Set/clear collision: r3 busy, ll_done r3 and fire id_long to r3 same cycle -> sb_busy[3] stays 1. Separately, WAW on busy r3 -> id_stall=1.
- r0 and unused ports: src=r0 with byp0 writing r0 rdy=0 -> operand 0, no stall. Unused port with hazard address -> no stall.
- Async reset mid-stall: rst asserted between clocks while sb_busy and stall_cnt are nonzero -> all cleared immediately; RF reads 0.
